div_iter: RTL and testbench
===========================

// Module: div_iter
// PURPOSE
//  Iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
//  - Driven by StartDivE from the EX pipeline register.
//  - Returns DivReadyE to the hazard unit, which holds F/D/E while StartDivE & ~DivReadyE.
//  - DivResultE {HI=remainder, LO=quotient} feeds the HI/LO write path through the M stage.
// PARAMETERS
//  WIDTH  32  operand width; result is 2*WIDTH; iteration count = WIDTH
// PORTS
//  clk           in   1        clock, rising edge
//  rst           in   1        synchronous active-high reset
//  StartDivE     in   1        divide request; held high until DivReadyE is seen
//  SignedDivE    in   1        1=DIV (two's complement), 0=DIVU
//  CancelDivE    in   1        abort (exception flush of EX); wins over everything except rst
//  SrcAE         in   WIDTH    dividend
//  SrcBE         in   WIDTH    divisor
//  DivReadyE     out  1        result valid this cycle (single-cycle pulse)
//  DivResultE    out  2*WIDTH  {remainder, quotient}; held stable until the next start
//  DivBusyE      out  1        state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; DivReadyE=0, DivBusyE=0, DivResultE=0, counter=0.
//  FSM states: IDLE, BUSY, DONE.
//  - IDLE: on StartDivE & ~CancelDivE, latch operands.
//    - Signed: convert to magnitudes; record qneg = signA^signB and rneg = signA.
//    - SrcBE==0 -> DONE; otherwise -> BUSY with counter=0.
//  - BUSY: one step per cycle.
//    - Shift {rem,quo} left 1; trial = rem - divisor (WIDTH+1 bits).
//    - Trial non-negative -> rem=trial and quo[0]=1.
//    - Stay in BUSY for WIDTH cycles (counter 0..WIDTH-1), then -> DONE.
//  - DONE: DivReadyE=1 for exactly one cycle.
//    - DivResultE is loaded here with signs applied: quotient negated if qneg, remainder negated if rneg.
//    - Then unconditionally -> IDLE. StartDivE still high in DONE is NOT a new request; the pipeline advances on the same edge.
//  Latency: start sampled at edge k; DivReadyE high in cycle k+WIDTH+1 (33 cycles for WIDTH=32).
//    - Back-to-back divides: the second request is accepted in the IDLE cycle after DONE.
//  Divide by zero: DivReadyE in cycle k+1; quotient = all ones, remainder = dividend (sign rules not applied).
//  Signed overflow: 0x80000000 / -1 gives quotient 0x80000000, remainder 0 (natural wrap, no trap).
//  Cancel: CancelDivE in BUSY or DONE -> IDLE next cycle; no DivReadyE pulse; DivResultE unchanged.
//  Reset mid-operation: returns to IDLE next edge; no pulse.
//  StartDivE dropping while BUSY (without cancel) is ignored; the operation completes.
// CONFIGURATION
//  DIV_EARLY_EXIT_EN defined:
//    - In IDLE, if divisor != 0 and |dividend| < |divisor| (after sign conversion), go directly to DONE.
//    - Quotient = 0, remainder = dividend; DivReadyE in cycle k+1.
//  Undefined: all nonzero-divisor operations take the full WIDTH+1 cycles.
//  Results are bit-identical in both builds; only latency differs.
// TESTING
//  1. DIVU 100/7, start held -> DivReadyE exactly at cycle 33; result {0x2, 0xE}; one-cycle pulse.
//  2. DIV -7/2 -> {0xFFFFFFFF, 0xFFFFFFFD}.
//     DIV 7/-2 -> {0x1, 0xFFFFFFFD}.
//     DIV 0x80000000/-1 -> {0x0, 0x80000000}.
//  3. DIVU 5/0 -> DivReadyE at cycle 1; result {0x5, 0xFFFFFFFF}.
//  4. Start, CancelDivE at cycle 10 -> idle at cycle 11, no pulse, prior result kept.
//     New start at cycle 12 completes normally.
//  5. Two back-to-back DIVU (9/3, then 8/3 accepted the cycle after DONE):
//     - Ready at 33 with {0,3}; Ready at 67 with {2,2}.
//     - No spurious restart while start is still high in DONE.
//  6. DIV_EARLY_EXIT_EN: DIVU 3/10 -> Ready at cycle 1 with {3,0}.
//     Without the macro -> Ready at cycle 33 with the same result.
//     rst at cycle 5 of any run -> DivBusyE=0 next cycle.

Source files
------------

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
// The result is packed as {remainder, quotient}. The divider performs one quotient
// bit per cycle, so a non-zero divisor takes WIDTH iterations plus one DONE cycle.
// Build option: define DIV_EARLY_EXIT_EN to finish at once when |dividend| < |divisor|.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for StartDivE; operands are latched on acceptance
//   BUSY  | one restoring step per cycle, cnt_q runs 0..WIDTH-1
//   DONE  | result valid (DivReadyE); committed to result_q on exit
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 StartDivE,
  input  logic                 SignedDivE,
  input  logic                 CancelDivE,
  input  logic [WIDTH-1:0]     SrcAE,
  input  logic [WIDTH-1:0]     SrcBE,
  output logic                 DivReadyE,
  output logic [2*WIDTH-1:0]   DivResultE,
  output logic                 DivBusyE
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     rem_q;
  logic [WIDTH-1:0]     quo_q;
  logic [WIDTH-1:0]     dvsr_q;
  logic                 qneg_q;
  logic                 rneg_q;
  logic                 ready_q;
  logic [2*WIDTH-1:0]   result_q;

  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic                 early_exit;
  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       trial;
  logic [WIDTH-1:0]     rem_d;
  logic [WIDTH-1:0]     quo_d;
  logic [WIDTH-1:0]     fin_rem;
  logic [WIDTH-1:0]     fin_quo;
  logic [2*WIDTH-1:0]   fin_res;

  // Operand magnitudes; the most negative value maps onto itself, which is the
  // correct unsigned magnitude.
  always_comb begin
    abs_a = (SignedDivE && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
    abs_b = (SignedDivE && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
  end

`ifdef DIV_EARLY_EXIT_EN
  // A dividend smaller than the divisor gives quotient 0 and needs no iterations.
  assign early_exit = (abs_a < abs_b);
`else
  assign early_exit = 1'b0;
`endif

  // One restoring step plus final sign fix-up of the held magnitudes.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};
    if (trial[WIDTH]) begin
      rem_d = shifted[WIDTH-1:0];
    end else begin
      rem_d = trial[WIDTH-1:0];
    end
    quo_d   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    fin_rem = rneg_q ? -rem_q : rem_q;
    fin_quo = qneg_q ? -quo_q : quo_q;
    fin_res = {fin_rem, fin_quo};
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else if (CancelDivE) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (StartDivE) begin
            cnt_q  <= '0;
            dvsr_q <= abs_b;
            if (SrcBE == '0) begin
              // Divide by zero: raw dividend and all-ones quotient, no sign fix-up.
              rem_q   <= SrcAE;
              quo_q   <= '1;
              qneg_q  <= 1'b0;
              rneg_q  <= 1'b0;
              ready_q <= 1'b1;
              state_q <= DONE;
            end else begin
              qneg_q <= SignedDivE & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
              rneg_q <= SignedDivE & SrcAE[WIDTH-1];
              if (early_exit) begin
                rem_q   <= abs_a;
                quo_q   <= '0;
                ready_q <= 1'b1;
                state_q <= DONE;
              end else begin
                rem_q   <= '0;
                quo_q   <= abs_a;
                state_q <= BUSY;
              end
            end
          end
        end
        BUSY: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            ready_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          // The request that produced this result is still held this cycle,
          // so leave unconditionally instead of treating it as a new start.
          result_q <= fin_res;
          ready_q  <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // A flush in the DONE cycle suppresses the pulse and keeps the previous result.
  assign DivReadyE  = ready_q & ~CancelDivE;
  assign DivResultE = DivReadyE ? fin_res : result_q;
  assign DivBusyE   = (state_q != IDLE);

endmodule

// File: tb/tb_div_iter.sv
// Directed testbench for div_iter. Cycle n is the clock period after the n-th
// rising edge counted from the edge at which the start request is sampled.
module tb_div_iter;

  localparam int W = 32;
`ifdef DIV_EARLY_EXIT_EN
  localparam int EE_LAT = 1;
`else
  localparam int EE_LAT = 33;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           StartDivE;
  logic           SignedDivE;
  logic           CancelDivE;
  logic [W-1:0]   SrcAE;
  logic [W-1:0]   SrcBE;
  logic           DivReadyE;
  logic [2*W-1:0] DivResultE;
  logic           DivBusyE;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  div_iter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .StartDivE  (StartDivE),
    .SignedDivE (SignedDivE),
    .CancelDivE (CancelDivE),
    .SrcAE      (SrcAE),
    .SrcBE      (SrcBE),
    .DivReadyE  (DivReadyE),
    .DivResultE (DivResultE),
    .DivBusyE   (DivBusyE)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Counts edges until DivReadyE is seen; -1 if it never shows up.
  task automatic wait_ready(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (DivReadyE) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic hold,
                        input logic [31:0] exp_rem, input logic [31:0] exp_quo,
                        input int exp_lat);
    int lat;
    SrcAE      = a;
    SrcBE      = b;
    SignedDivE = sgn;
    StartDivE  = 1'b1;
    wait_ready(lat);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, DivResultE, {exp_rem, exp_quo});
    if (!hold) StartDivE = 1'b0;
    @(posedge clk); #1;
    chk({tag, " pulse"}, 64'(DivReadyE), 64'd0);
    chk({tag, " idle"}, 64'(DivBusyE), 64'd0);
    chk({tag, " held"}, DivResultE, {exp_rem, exp_quo});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  lat;
    bit  seen;
    rst        = 1'b1;
    StartDivE  = 1'b0;
    SignedDivE = 1'b0;
    CancelDivE = 1'b0;
    SrcAE      = '0;
    SrcBE      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 64'(DivReadyE), 64'd0);
    chk("reset busy", 64'(DivBusyE), 64'd0);
    chk("reset result", DivResultE, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_div("divu_100_7", 32'd100, 32'd7, 1'b0, 1'b0, 32'h2, 32'hE, 33);
    do_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    do_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h1, 32'hFFFF_FFFD, 33);
    do_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 32'h8000_0000, 33);
    do_div("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 33);
    do_div("divu_5_0", 32'd5, 32'd0, 1'b0, 1'b0, 32'h5, 32'hFFFF_FFFF, 1);
    do_div("div_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1);

    // Cancel while BUSY: request at edge 0, flush in cycle 10, idle in cycle 11.
    SrcAE = 32'd100; SrcBE = 32'd7; SignedDivE = 1'b0; StartDivE = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("cancel_busy running", 64'(DivBusyE), 64'd1);
    CancelDivE = 1'b1;
    @(posedge clk); #1;
    chk("cancel_busy idle", 64'(DivBusyE), 64'd0);
    chk("cancel_busy no pulse", 64'(DivReadyE), 64'd0);
    chk("cancel_busy result kept", DivResultE, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
    CancelDivE = 1'b0;
    StartDivE  = 1'b0;
    @(posedge clk); #1;
    do_div("after_cancel_9_4", 32'd9, 32'd4, 1'b0, 1'b0, 32'h1, 32'h2, 33);

    // Cancel in the DONE cycle of a divide by zero.
    SrcAE = 32'd9; SrcBE = 32'd0; SignedDivE = 1'b0; StartDivE = 1'b1;
    @(posedge clk); #1;
    chk("cancel_done in done", 64'(DivBusyE), 64'd1);
    CancelDivE = 1'b1;
    #1;
    chk("cancel_done no pulse", 64'(DivReadyE), 64'd0);
    chk("cancel_done result kept", DivResultE, {32'h1, 32'h2});
    @(posedge clk); #1;
    CancelDivE = 1'b0;
    StartDivE  = 1'b0;
    chk("cancel_done idle", 64'(DivBusyE), 64'd0);
    chk("cancel_done result after", DivResultE, {32'h1, 32'h2});

    // Back-to-back: start held through DONE, next operands accepted one cycle later.
    do_div("b2b_9_3", 32'd9, 32'd3, 1'b0, 1'b1, 32'h0, 32'h3, 33);
    do_div("b2b_8_3", 32'd8, 32'd3, 1'b0, 1'b0, 32'h2, 32'h2, 33);

    // StartDivE dropped during BUSY: the operation still completes.
    SrcAE = 32'd1000; SrcBE = 32'd10; SignedDivE = 1'b0; StartDivE = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    StartDivE = 1'b0;
    wait_ready(lat);
    chk("drop_start latency", 64'(lat + 3), 64'd33);
    chk("drop_start result", DivResultE, {32'h0, 32'h64});
    @(posedge clk); #1;

    do_div("divu_3_10", 32'd3, 32'd10, 1'b0, 1'b0, 32'h3, 32'h0, EE_LAT);
    do_div("div_m3_10", 32'hFFFF_FFFD, 32'd10, 1'b1, 1'b0, 32'hFFFF_FFFD, 32'h0, EE_LAT);

    // Reset in cycle 5 of a running divide.
    SrcAE = 32'd100; SrcBE = 32'd7; SignedDivE = 1'b0; StartDivE = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid running", 64'(DivBusyE), 64'd1);
    rst       = 1'b1;
    StartDivE = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid busy", 64'(DivBusyE), 64'd0);
    chk("rst_mid ready", 64'(DivReadyE), 64'd0);
    chk("rst_mid result", DivResultE, 64'd0);
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (DivReadyE) seen = 1'b1;
    end
    chk("rst_mid no late pulse", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
